// File: rtl/window_streamer.sv
// window_streamer: turns a raster-order pixel stream into K x K windows at stride STRIDE.
// K-1 line buffers supply the rows above the incoming pixel; a column shift register assembles the window.
module window_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int PW     = 8,
    parameter int STRIDE = 1,
    parameter int CW     = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [PW-1:0]       PIX,
    input  logic                PIX_VALID,
    output logic                PIX_READY,
    output logic [K*K*PW-1:0]   IMGIN,
    output logic [CW-1:0]       X,
    output logic [CW-1:0]       Y,
    output logic                WIN_VALID,
    input  logic                WIN_READY,
    output logic                DONE,
    output logic                BUSY
);
    localparam int RW  = $clog2(IMG_H);
    localparam int CCW = $clog2(IMG_W);
    localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_r;
    logic [1:0]          state_next_s;
    logic [RW-1:0]       row_r;
    logic [CCW-1:0]      col_r;
    logic [PHW-1:0]      row_ph_r;
    logic [PHW-1:0]      col_ph_r;
    logic [PHW-1:0]      row_ph_next_s;
    logic [PHW-1:0]      col_ph_next_s;
    logic                win_valid_r;
    logic [K*K*PW-1:0]   imgin_r;
    logic [CW-1:0]       x_r;
    logic [CW-1:0]       y_r;
    logic                done_r;
    logic                busy_r;

    logic                pix_ready_s;
    logic                accept_s;
    logic                emit_s;
    logic                col_last_s;
    logic                row_last_s;
    logic [PW-1:0]       col_s [K];
    logic [K*K*PW-1:0]   win_next_s;

    // Pixel storage only; never exposed before it has been overwritten with frame data
    logic [PW-1:0]       lb_r   [K-1][IMG_W];
    logic [PW-1:0]       hist_r [K][K-1];

    // Input handshake, window emission condition and raster position flags
    always_comb begin
        if (state_r == S_RUN) begin
            pix_ready_s = !win_valid_r || WIN_READY;
        end else begin
            pix_ready_s = 1'b0;
        end
        accept_s   = pix_ready_s && PIX_VALID;
        col_last_s = (col_r == CCW'(IMG_W - 1));
        row_last_s = (row_r == RW'(IMG_H - 1));
        emit_s     = accept_s
                     && (row_r >= RW'(K - 1)) && (col_r >= CCW'(K - 1))
                     && (row_ph_r == PHW'(0)) && (col_ph_r == PHW'(0));
    end

    // Stride phase of the next row/column; phases only start counting once a window fits
    always_comb begin
        if (col_r < CCW'(K - 1)) begin
            col_ph_next_s = PHW'(0);
        end else if (col_ph_r == PHW'(STRIDE - 1)) begin
            col_ph_next_s = PHW'(0);
        end else begin
            col_ph_next_s = col_ph_r + PHW'(1);
        end
        if (row_r < RW'(K - 1)) begin
            row_ph_next_s = PHW'(0);
        end else if (row_ph_r == PHW'(STRIDE - 1)) begin
            row_ph_next_s = PHW'(0);
        end else begin
            row_ph_next_s = row_ph_r + PHW'(1);
        end
    end

    // Frame sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (START) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && col_last_s && row_last_s) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!win_valid_r || WIN_READY) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Newest window column: incoming pixel at the bottom, older rows from the line buffers above it
    always_comb begin
        for (int i = 0; i < K; i++) begin
            col_s[i] = {PW{1'b0}};
        end
        col_s[K-1] = PIX;
        for (int k = 0; k < K - 1; k++) begin
            col_s[K-2-k] = lb_r[k][col_r];
        end
    end

    // Window ending at the current pixel, packed row-major
    always_comb begin
        win_next_s = {(K*K*PW){1'b0}};
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_next_s[(i*K+j)*PW +: PW] = hist_r[i][j];
            end
            win_next_s[(i*K+K-1)*PW +: PW] = col_s[i];
        end
    end

    // Line buffers and window history shift on every accepted pixel
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            lb_r[0][col_r] <= PIX;
            for (int k = 1; k < K - 1; k++) begin
                lb_r[k][col_r] <= lb_r[k-1][col_r];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    hist_r[i][j] <= win_next_s[(i*K+j+1)*PW +: PW];
                end
            end
        end
    end

    // State register with registered BUSY/DONE derived from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Raster position and stride phase counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_r    <= RW'(0);
            col_r    <= CCW'(0);
            row_ph_r <= PHW'(0);
            col_ph_r <= PHW'(0);
        end else if ((state_r == S_IDLE) && START) begin
            row_r    <= RW'(0);
            col_r    <= CCW'(0);
            row_ph_r <= PHW'(0);
            col_ph_r <= PHW'(0);
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r    <= CCW'(0);
                col_ph_r <= PHW'(0);
                if (row_last_s) begin
                    row_r    <= RW'(0);
                    row_ph_r <= PHW'(0);
                end else begin
                    row_r    <= row_r + RW'(1);
                    row_ph_r <= row_ph_next_s;
                end
            end else begin
                col_r    <= col_r + CCW'(1);
                col_ph_r <= col_ph_next_s;
            end
        end
    end

    // Output window register; a new window may replace one being consumed in the same cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win_valid_r <= 1'b0;
            imgin_r     <= {(K*K*PW){1'b0}};
            x_r         <= CW'(0);
            y_r         <= CW'(0);
        end else if (emit_s) begin
            win_valid_r <= 1'b1;
            imgin_r     <= win_next_s;
            x_r         <= CW'(row_r - RW'(K - 1));
            y_r         <= CW'(col_r - CCW'(K - 1));
        end else if (win_valid_r && WIN_READY) begin
            win_valid_r <= 1'b0;
        end
    end

    assign PIX_READY = pix_ready_s;
    assign IMGIN     = imgin_r;
    assign X         = x_r;
    assign Y         = y_r;
    assign WIN_VALID = win_valid_r;
    assign DONE      = done_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_window_streamer.sv
// Directed bench for window_streamer: scoreboard of expected windows fed by a reference slicer model.
module tb_window_streamer;
    localparam int KK = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a;
    logic         start_b;
    logic [7:0]   pix;
    logic         pix_valid;
    logic         win_ready;

    logic         pix_ready_a, win_valid_a, done_a, busy_a;
    logic [199:0] imgin_a;
    logic [4:0]   x_a, y_a;
    logic         pix_ready_b, win_valid_b, done_b, busy_b;
    logic [199:0] imgin_b;
    logic [4:0]   x_b, y_b;

    always #5 clk = ~clk;

    window_streamer #(.IMG_W(28), .IMG_H(28), .K(5), .PW(8), .STRIDE(1), .CW(5)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .PIX(pix), .PIX_VALID(pix_valid),
        .PIX_READY(pix_ready_a), .IMGIN(imgin_a), .X(x_a), .Y(y_a),
        .WIN_VALID(win_valid_a), .WIN_READY(win_ready), .DONE(done_a), .BUSY(busy_a)
    );

    window_streamer #(.IMG_W(27), .IMG_H(27), .K(5), .PW(8), .STRIDE(2), .CW(5)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .PIX(pix), .PIX_VALID(pix_valid),
        .PIX_READY(pix_ready_b), .IMGIN(imgin_b), .X(x_b), .Y(y_b),
        .WIN_VALID(win_valid_b), .WIN_READY(win_ready), .DONE(done_b), .BUSY(busy_b)
    );

    int           checks = 0;
    int           errors = 0;
    int           sel = 0;
    int           w = 28;
    int           stride = 1;
    int           total = 576;
    int           mr = 0;
    int           mc = 0;
    int           popped = 0;
    logic         feeding = 1'b0;
    logic         in_frame = 1'b0;
    logic         exp_done = 1'b0;
    logic         prev_stall = 1'b0;
    logic [209:0] hold_vec;
    logic [209:0] first_vec;
    logic [209:0] last_vec;
    logic [209:0] exp_q [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixv(input int r, input int c);
        int v;
        v = r * w + c;
        return v[7:0];
    endfunction

    function automatic logic emits(input int r, input int c);
        return (r >= KK - 1) && (c >= KK - 1)
               && (((r - KK + 1) % stride) == 0) && (((c - KK + 1) % stride) == 0);
    endfunction

    function automatic logic [209:0] model_win(input int r, input int c);
        logic [199:0] img;
        int x, y;
        logic [4:0] xs, ys;
        x = r - (KK - 1);
        y = c - (KK - 1);
        for (int i = 0; i < KK; i++)
            for (int j = 0; j < KK; j++)
                img[(i*KK+j)*8 +: 8] = pixv(x + i, y + j);
        xs = x[4:0];
        ys = y[4:0];
        return {xs, ys, img};
    endfunction

    // one clock: check outputs at the falling edge, update the model, return just after the rising edge
    task automatic tick();
        logic o_pr, o_wv, o_done, o_busy;
        logic [209:0] o_vec;
        logic exp_pr, acc, hs, cur_done;
        logic [209:0] e;
        @(negedge clk);
        if (sel == 0) begin
            o_pr = pix_ready_a; o_wv = win_valid_a; o_done = done_a; o_busy = busy_a;
            o_vec = {x_a, y_a, imgin_a};
        end else begin
            o_pr = pix_ready_b; o_wv = win_valid_b; o_done = done_b; o_busy = busy_b;
            o_vec = {x_b, y_b, imgin_b};
        end
        exp_pr = feeding && ((exp_q.size() == 0) || win_ready);
        chk("pix_ready", 256'(o_pr), 256'(exp_pr));
        chk("win_valid", 256'(o_wv), 256'(exp_q.size() != 0));
        chk("busy", 256'(o_busy), 256'(in_frame));
        chk("done", 256'(o_done), 256'(exp_done));
        if (prev_stall) chk("hold", 256'(o_vec), 256'(hold_vec));
        cur_done = exp_done;
        exp_done = 1'b0;
        acc = pix_valid && exp_pr;
        hs = (exp_q.size() != 0) && win_ready;
        if (hs) begin
            e = exp_q.pop_front();
            chk("window", 256'(o_vec), 256'(e));
            if (popped == 0) first_vec = o_vec;
            last_vec = o_vec;
            popped++;
        end
        if (acc) begin
            if (emits(mr, mc)) exp_q.push_back(model_win(mr, mc));
            mc++;
            if (mc == w) begin
                mc = 0;
                mr++;
                if (mr == w) feeding = 1'b0;
            end
        end
        if (hs && (exp_q.size() == 0) && !feeding) exp_done = 1'b1;
        if (cur_done) in_frame = 1'b0;
        prev_stall = o_wv && !win_ready;
        hold_vec = o_vec;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int pv_mode, input int wr_mode, input bit mid_start, input bit abort);
        int guard;
        bit started_mid;
        bit aborted;
        logic o_wv, o_busy, o_pr;
        exp_q.delete();
        mr = 0; mc = 0; popped = 0; prev_stall = 1'b0; exp_done = 1'b0;
        started_mid = 1'b0; aborted = 1'b0;
        pix_valid = 1'b0; win_ready = 1'b1; pix = 8'h00;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        feeding = 1'b1; in_frame = 1'b1;
        guard = 0;
        while (in_frame && guard < 20000) begin
            if (abort && popped == 300) begin
                rst = 1'b1;
                #1;
                o_wv   = (sel == 0) ? win_valid_a : win_valid_b;
                o_busy = (sel == 0) ? busy_a : busy_b;
                o_pr   = (sel == 0) ? pix_ready_a : pix_ready_b;
                chk("abort_win_valid", 256'(o_wv), 256'(1'b0));
                chk("abort_busy", 256'(o_busy), 256'(1'b0));
                chk("abort_pix_ready", 256'(o_pr), 256'(1'b0));
                exp_q.delete();
                feeding = 1'b0; in_frame = 1'b0; exp_done = 1'b0; prev_stall = 1'b0;
                tick();
                tick();
                rst = 1'b0;
                tick();
                aborted = 1'b1;
                break;
            end
            pix_valid = (pv_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            win_ready = (wr_mode != 0) ? ((guard % 2) == 0) : 1'b1;
            pix = feeding ? pixv(mr, mc) : 8'h00;
            if (mid_start && !started_mid && popped == 100) begin
                started_mid = 1'b1;
                if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            tick();
            start_a = 1'b0; start_b = 1'b0;
            guard++;
        end
        pix_valid = 1'b0; win_ready = 1'b1;
        if (!aborted) begin
            chk("frame_completed", 256'(in_frame), 256'(1'b0));
            chk("window_count", 256'(popped), 256'(total));
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        pix = 8'h00; pix_valid = 1'b0; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_win_valid", 256'({win_valid_a, win_valid_b}), 256'(2'b00));
        chk("rst_busy", 256'({busy_a, busy_b}), 256'(2'b00));
        chk("rst_done", 256'({done_a, done_b}), 256'(2'b00));
        chk("rst_pix_ready", 256'({pix_ready_a, pix_ready_b}), 256'(2'b00));
        chk("rst_imgin", 256'(imgin_a), 256'(0));
        chk("rst_xy", 256'({x_a, y_a, x_b, y_b}), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // full-rate default frame
        run_frame(0, 0, 1'b0, 1'b0);
        chk("first_x", 256'(first_vec[209:205]), 256'(5'd0));
        chk("first_y", 256'(first_vec[204:200]), 256'(5'd0));
        chk("first_pix00", 256'(first_vec[7:0]), 256'(8'h00));
        chk("first_pix44", 256'(first_vec[199:192]), 256'(8'h74));
        chk("last_x", 256'(last_vec[209:205]), 256'(5'd23));
        chk("last_y", 256'(last_vec[204:200]), 256'(5'd23));

        // downstream stalls every other cycle
        run_frame(0, 1, 1'b0, 1'b0);
        // bursty source
        run_frame(1, 0, 1'b0, 1'b0);
        // abort after 300 windows, then a fresh frame
        run_frame(0, 0, 1'b0, 1'b1);
        run_frame(0, 0, 1'b0, 1'b0);
        chk("restart_first_xy", 256'(first_vec[209:200]), 256'(10'd0));
        // START while busy is ignored
        run_frame(0, 0, 1'b1, 1'b0);

        // stride-2 instance on a 27x27 frame
        sel = 1; w = 27; stride = 2; total = 144;
        run_frame(0, 0, 1'b0, 1'b0);
        chk("s2_first_xy", 256'(first_vec[209:200]), 256'(10'd0));
        chk("s2_last_x", 256'(last_vec[209:205]), 256'(5'd22));
        chk("s2_last_y", 256'(last_vec[204:200]), 256'(5'd22));
        run_frame(1, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_streamer.md
Name: window_streamer

Overview:
- Hardware successor to the bench-side 5x5 window slicer in front of simpleCNN.
- Accepts a raster-order pixel stream for one IMG_H x IMG_W frame and emits every K x K window at stride STRIDE, packed in the same IMGIN layout, with its top-left coordinates X/Y.
- Uses (K-1) line buffers plus a K x K shift register, with valid/ready backpressure on both sides.
- Sits between the image source and the CNN core; replaces the bench loop.

Parameters:
- IMG_W, 28, frame width in pixels.
- IMG_H, 28, frame height in pixels.
- K, 5, window size. Must satisfy 2 <= K <= min(IMG_W, IMG_H).
- PW, 8, pixel width in bits.
- STRIDE, 1, window step. Requires (IMG_W-K)%STRIDE==0 and (IMG_H-K)%STRIDE==0.
- CW, 5, width of X/Y. Requires 2^CW > max(IMG_W, IMG_H)-K.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- PIX  in  PW  input pixel.
- PIX_VALID  in  1  PIX is valid.
- PIX_READY  out  1  block accepts PIX this cycle.
- IMGIN  out  K*K*PW  window; pixel (row i, col j) at bits [(i*K+j)*PW +: PW].
- X  out  CW  window top-left row.
- Y  out  CW  window top-left column.
- WIN_VALID  out  1  IMGIN/X/Y valid.
- WIN_READY  in  1  downstream accepts the window.
- DONE  out  1  one-cycle pulse once the frame's last window is consumed.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous) clears:
  - state to IDLE and all counters;
  - PIX_READY, WIN_VALID, DONE and BUSY to 0;
  - IMGIN, X and Y to 0.
- Line-buffer contents need not be cleared.
- States:
  - IDLE: START -> RUN; clears row/col counters r=c=0.
  - RUN: PIX_READY = !WIN_VALID || WIN_READY. A pixel is accepted when PIX_VALID && PIX_READY.
    - Each accepted pixel at (r,c): shift into line buffers and window column, then advance c. On c==IMG_W-1, c wraps to 0 and r increments.
    - Emit condition: r>=K-1, c>=K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0. When it holds, on the next edge: IMGIN = window ending at (r,c); X = r-K+1; Y = c-K+1; WIN_VALID = 1.
    - Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: PIX_READY=0. When WIN_VALID==0, or the handshake completes (WIN_VALID && WIN_READY), -> DONE.
  - DONE: DONE=1 for exactly one cycle, then IDLE.
- Window handshake:
  - WIN_VALID, IMGIN, X and Y hold stable until WIN_VALID && WIN_READY.
  - WIN_VALID clears after the handshake unless a new window is produced the same cycle. A simultaneous handshake and new pixel is allowed: one window per cycle at full throughput.
- Latency: 1 cycle from accepting the completing pixel to WIN_VALID.
- Window count per frame: ((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1). This is 576 at defaults; 144 at STRIDE=2 with IMG=27, K=5.
- Pixels on rows/columns that produce no window (stride skips) are still accepted and buffered.
- START while BUSY is ignored, with no counter disturbance.
- START and RST together: RST wins.
- RST mid-frame aborts immediately; the next frame needs a fresh START.
- PIX_VALID in IDLE/DONE is not accepted (PIX_READY=0).
- Column wrap: the window register is column-shifted only. Windows are never emitted for c<K-1, so stale data from the previous row is never exposed.

Test Plan:
- Defaults; frame pixel(r,c)=(r*28+c)&8'hFF; WIN_READY=1; PIX_VALID=1 -> 576 windows in raster order.
  - First window X=0, Y=0, IMGIN[7:0]=8'h00, IMGIN[199:192]=8'h74.
  - Last window X=23, Y=23.
  - DONE one cycle after the last window; matches the bench slicer output exactly.
- Same frame, WIN_READY toggling 1/0 every cycle -> identical 576-window sequence.
  - Throughout, PIX_READY=0 whenever WIN_VALID && !WIN_READY.
  - Outputs hold stable while stalled.
- STRIDE=2, IMG_W=IMG_H=27, K=5 -> 144 windows, X and Y in {0,2,...,22}, DONE after the 144th.
- PIX_VALID random 50% duty, WIN_READY=1 -> same 576 windows as the first scenario. No duplicates and no drops.
- RST asserted after 300 windows -> within the same cycle WIN_VALID=0, BUSY=0, PIX_READY=0.
  - New START with a fresh frame yields the full 576 windows starting at X=0, Y=0.
- START pulsed during RUN at window 100 -> ignored; the frame completes normally with 576 windows and a single DONE.
